// File: rtl/spi_txn_sequencer.sv
// Frames a {last, byte} command stream into chip-select transactions for SPI_Controller_With_Single_CS.
// Define SPI_SEQ_RSP_EN to build the response FIFO, RX last-marking counter and overflow flag.

module spi_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

module spi_txn_sequencer #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int FIFO_DEPTH       = 8,
    localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Cmd_Valid,
    output logic          o_Cmd_Ready,
    input  logic [7:0]    i_Cmd_Byte,
    input  logic          i_Cmd_Last,
    output logic [CW-1:0] o_TX_Count,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Rsp_Valid,
    input  logic          i_Rsp_Ready,
    output logic [7:0]    o_Rsp_Byte,
    output logic          o_Rsp_Last,
    output logic          o_Busy,
    output logic          o_Err_Len,
    output logic          o_Rsp_Overflow
);
    localparam logic [CW-1:0] MAX_LEN = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] remain_q, remain_d;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic [CW-1:0] run_len_q, run_len_d;
    logic          err_len_q, err_len_d;

    logic          cmd_push, cmd_pop, cmd_empty, cmd_full;
    logic [8:0]    cmd_head;
    logic          len_push, len_pop, len_empty, len_full;
    logic [CW-1:0] len_head, run_len_inc;

    assign cmd_push = i_Cmd_Valid && o_Cmd_Ready;
    assign cmd_pop  = (state_q == ST_ISSUE);

    spi_seq_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .wdata ({i_Cmd_Last, i_Cmd_Byte}),
        .rdata (cmd_head),
        .empty (cmd_empty),
        .full  (cmd_full)
    );

    // Every length entry stands for at least one byte already in the command FIFO, so it never overflows.
    spi_seq_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_len_fifo (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .push  (len_push),
        .pop   (len_pop),
        .wdata (run_len_inc),
        .rdata (len_head),
        .empty (len_empty),
        .full  (len_full)
    );

    always_comb begin
        run_len_inc = run_len_q + 1'b1;
        len_push    = 1'b0;
        run_len_d   = run_len_q;
        err_len_d   = err_len_q;
        if (cmd_push) begin
            if (i_Cmd_Last || (run_len_inc == MAX_LEN)) begin
                len_push  = 1'b1;
                run_len_d = '0;
                err_len_d = err_len_q | !i_Cmd_Last;
            end else begin
                run_len_d = run_len_inc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        tx_count_d = tx_count_q;
        len_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!len_empty && i_TX_Ready) begin
                    len_pop    = 1'b1;
                    tx_count_d = len_head;
                    remain_d   = len_head;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                remain_d = remain_q - 1'b1;
                state_d  = ST_GAP;
            end
            // The controller's ready still reflects the byte just strobed, so skip one cycle.
            ST_GAP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (remain_q == '0) begin
                    state_d = ST_IDLE;
                end else if (i_TX_Ready) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            tx_count_q <= '0;
            run_len_q  <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            tx_count_q <= tx_count_d;
            run_len_q  <= run_len_d;
            err_len_q  <= err_len_d;
        end
    end

    assign o_Cmd_Ready = !cmd_full;
    assign o_TX_DV     = (state_q == ST_ISSUE);
    assign o_TX_Byte   = o_TX_DV ? cmd_head[7:0] : 8'h00;
    assign o_TX_Count  = tx_count_q;
    assign o_Busy      = (state_q != ST_IDLE) || !cmd_empty;
    assign o_Err_Len   = err_len_q;

`ifdef SPI_SEQ_RSP_EN
    logic [CW-1:0] rx_len_q, rx_len_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, rx_cnt_inc;
    logic          rx_last, ovf_q, ovf_d;
    logic          rsp_pop, rsp_empty, rsp_full;
    logic [8:0]    rsp_head;

    // The received count keeps advancing on dropped bytes so later last markers stay aligned.
    always_comb begin
        rx_len_d   = len_pop ? len_head : rx_len_q;
        rx_cnt_inc = rx_cnt_q + 1'b1;
        rx_last    = (rx_cnt_inc == rx_len_q);
        rx_cnt_d   = rx_cnt_q;
        ovf_d      = ovf_q;
        if (i_RX_DV) begin
            rx_cnt_d = rx_last ? '0 : rx_cnt_inc;
            ovf_d    = ovf_q | rsp_full;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_len_q <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rx_len_q <= rx_len_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rsp_pop = o_Rsp_Valid && i_Rsp_Ready;

    spi_seq_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .push  (i_RX_DV),
        .pop   (rsp_pop),
        .wdata ({rx_last, i_RX_Byte}),
        .rdata (rsp_head),
        .empty (rsp_empty),
        .full  (rsp_full)
    );

    assign o_Rsp_Valid    = !rsp_empty;
    assign o_Rsp_Byte     = o_Rsp_Valid ? rsp_head[7:0] : 8'h00;
    assign o_Rsp_Last     = o_Rsp_Valid && rsp_head[8];
    assign o_Rsp_Overflow = ovf_q;

    logic unused_ok;
    assign unused_ok = ^{len_full, cmd_head[8]};
`else
    assign o_Rsp_Valid    = 1'b0;
    assign o_Rsp_Byte     = 8'h00;
    assign o_Rsp_Last     = 1'b0;
    assign o_Rsp_Overflow = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{len_full, cmd_head[8], i_RX_DV, i_RX_Byte, i_Rsp_Ready};
`endif
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: a frame-level model of the command stream and response
// stream is checked against the DUT every cycle, alongside hand-computed literal expectations.

module tb_spi_txn_sequencer;
    localparam int MAXB  = 2;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
`ifdef SPI_SEQ_RSP_EN
    localparam bit RSP_EN = 1'b1;
`else
    localparam bit RSP_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          i_Cmd_Valid, o_Cmd_Ready, i_Cmd_Last;
    logic [7:0]    i_Cmd_Byte;
    logic [CW-1:0] o_TX_Count;
    logic [7:0]    o_TX_Byte;
    logic          o_TX_DV, i_TX_Ready, i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic          o_Rsp_Valid, i_Rsp_Ready, o_Rsp_Last;
    logic [7:0]    o_Rsp_Byte;
    logic          o_Busy, o_Err_Len, o_Rsp_Overflow;

    spi_txn_sequencer #(.MAX_BYTES_PER_CS(MAXB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Cmd_Valid    (i_Cmd_Valid),
        .o_Cmd_Ready    (o_Cmd_Ready),
        .i_Cmd_Byte     (i_Cmd_Byte),
        .i_Cmd_Last     (i_Cmd_Last),
        .o_TX_Count     (o_TX_Count),
        .o_TX_Byte      (o_TX_Byte),
        .o_TX_DV        (o_TX_DV),
        .i_TX_Ready     (i_TX_Ready),
        .i_RX_DV        (i_RX_DV),
        .i_RX_Byte      (i_RX_Byte),
        .o_Rsp_Valid    (o_Rsp_Valid),
        .i_Rsp_Ready    (i_Rsp_Ready),
        .o_Rsp_Byte     (o_Rsp_Byte),
        .o_Rsp_Last     (o_Rsp_Last),
        .o_Busy         (o_Busy),
        .o_Err_Len      (o_Err_Len),
        .o_Rsp_Overflow (o_Rsp_Overflow)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_tx_q[$];   // {count, byte} per expected strobe
    logic [8:0]  exp_rsp_q[$];  // {last, byte} per expected response
    logic [7:0]  cur_frame[$];  // bytes of the frame still being assembled
    int          accepted = 0;
    int          issued   = 0;
    int          dv_cnt   = 0;
    int          dv_age   = 3;  // cycles since the last strobe, saturating
    bit          exp_err  = 1'b0;
    bit          exp_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        exp_tx_q.delete();
        exp_rsp_q.delete();
        cur_frame.delete();
        accepted = 0;
        issued   = 0;
        dv_age   = 3;
        exp_err  = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    // Per-cycle compare on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin : compare
        logic [15:0] e;
        logic [8:0]  r;
        if (rst_n) begin
            check("cmd_ready", o_Cmd_Ready, (accepted - issued) < DEPTH);
            check("busy", o_Busy, (accepted != issued) || (dv_age < 2));
            check("err_len", o_Err_Len, exp_err);
            check("rsp_overflow", o_Rsp_Overflow, exp_ovf);
            check("rsp_valid", o_Rsp_Valid, exp_rsp_q.size() != 0);
            if (!o_Rsp_Valid) check("rsp_idle_zero", {o_Rsp_Last, o_Rsp_Byte}, 0);
            if (o_TX_DV) begin
                check("tx_spacing", dv_age >= 2, 1);
                check("tx_dv_pending", exp_tx_q.size() != 0, 1);
                if (exp_tx_q.size() != 0) begin
                    e = exp_tx_q.pop_front();
                    check("tx_byte", o_TX_Byte, e[7:0]);
                    check("tx_count", o_TX_Count, e[15:8]);
                end
                issued++;
                dv_cnt++;
                dv_age = 0;
            end else if (dv_age < 3) begin
                dv_age++;
            end
            if (o_Rsp_Valid && i_Rsp_Ready && exp_rsp_q.size() != 0) begin
                r = exp_rsp_q.pop_front();
                check("rsp_byte", o_Rsp_Byte, r[7:0]);
                check("rsp_last", o_Rsp_Last, r[8]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b, input logic l);
        int n = 0;
        i_Cmd_Valid = 1'b1;
        i_Cmd_Byte  = b;
        i_Cmd_Last  = l;
        @(negedge clk);
        while (!o_Cmd_Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_wait", o_Cmd_Ready, 1'b1);
        @(posedge clk);
        accepted++;
        cur_frame.push_back(b);
        if (l || cur_frame.size() == MAXB) begin
            if (!l) exp_err = 1'b1;
            foreach (cur_frame[i]) exp_tx_q.push_back({8'(cur_frame.size()), cur_frame[i]});
            cur_frame.delete();
        end
        #1 i_Cmd_Valid = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] b, input logic l);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(posedge clk);
        if (RSP_EN) begin
            if (exp_rsp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_rsp_q.push_back({l, b});
        end
        #1 i_RX_DV = 1'b0;
    endtask

    task automatic wait_dv(input int target, input string name);
        int n = 0;
        while (dv_cnt < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, dv_cnt >= target, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_tx_q.size() != 0 || dv_age < 3) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_tx_q.size(), 0);
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_tx_dv"}, o_TX_DV, 0);
        check({p, "_tx_count"}, o_TX_Count, 0);
        check({p, "_tx_byte"}, o_TX_Byte, 0);
        check({p, "_rsp_valid"}, o_Rsp_Valid, 0);
        check({p, "_rsp_byte"}, o_Rsp_Byte, 0);
        check({p, "_rsp_last"}, o_Rsp_Last, 0);
        check({p, "_busy"}, o_Busy, 0);
        check({p, "_err_len"}, o_Err_Len, 0);
        check({p, "_rsp_overflow"}, o_Rsp_Overflow, 0);
        check({p, "_cmd_ready"}, o_Cmd_Ready, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst_n       = 1'b0;
        i_Cmd_Valid = 1'b0;
        i_Cmd_Byte  = 8'h00;
        i_Cmd_Last  = 1'b0;
        i_TX_Ready  = 1'b1;
        i_RX_DV     = 1'b0;
        i_RX_Byte   = 8'h00;
        i_Rsp_Ready = 1'b1;
        reset_model();
        #1 check_reset_values("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-byte frame: strobe two cycles after acceptance, then one response.
        push(8'hA5, 1'b1);
        @(negedge clk);
        check("t1_dv_early", o_TX_DV, 0);
        @(negedge clk);
        check("t1_dv", o_TX_DV, 1);
        check("t1_count", o_TX_Count, 1);
        check("t1_byte", o_TX_Byte, 8'hA5);
        @(posedge clk);
        #1;
        wait_idle("t1_drain");
        rx_strobe(8'h3C, 1'b1);
        @(negedge clk);
        check("t1_rsp_valid", o_Rsp_Valid, RSP_EN);
        check("t1_rsp_byte", o_Rsp_Byte, RSP_EN ? 8'h3C : 8'h00);
        check("t1_rsp_last", o_Rsp_Last, RSP_EN);
        @(posedge clk);
        #1;

        // Two-byte frame with the controller stalling between strobes.
        base = dv_cnt;
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        wait_dv(base + 1, "t2_first_dv");
        i_TX_Ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t2_stall_no_dv", dv_cnt, base + 1);
        check("t2_count_hold", o_TX_Count, 2);
        i_TX_Ready = 1'b1;
        wait_dv(base + 2, "t2_second_dv");
        wait_idle("t2_drain");
        rx_strobe(8'hB1, 1'b0);
        rx_strobe(8'hB2, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Over-length frame is split 2 + 1 and flags the length error.
        check("t3_err_before", o_Err_Len, 0);
        base = dv_cnt;
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        wait_idle("t3_drain");
        check("t3_dv_total", dv_cnt - base, 3);
        check("t3_err_after", o_Err_Len, 1);

        // Fill the command FIFO with the controller held off.
        i_TX_Ready = 1'b0;
        for (int k = 0; k < 8; k++) push(8'h40 + 8'(k), k[0]);
        @(negedge clk);
        check("t4_cmd_full", o_Cmd_Ready, 0);
        i_Cmd_Valid = 1'b1;
        i_Cmd_Byte  = 8'h99;
        i_Cmd_Last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_no_accept", o_Cmd_Ready, 0);
        end
        i_Cmd_Valid = 1'b0;
        @(posedge clk);
        #1;
        base = dv_cnt;
        i_TX_Ready = 1'b1;
        wait_dv(base + 8, "t4_all_issued");
        wait_idle("t4_drain");

        // Response overflow: length-2 frame, 9 strobes with the consumer stalled.
        push(8'h5A, 1'b0);
        push(8'h5B, 1'b1);
        wait_idle("t5_drain_tx");
        i_Rsp_Ready = 1'b0;
        for (int k = 0; k < 9; k++) rx_strobe(8'hC0 + 8'(k), k[0]);
        @(negedge clk);
        check("t5_overflow", o_Rsp_Overflow, RSP_EN);
        check("t5_head", o_Rsp_Byte, RSP_EN ? 8'hC0 : 8'h00);
        @(posedge clk);
        #1;
        i_Rsp_Ready = 1'b1;
        begin
            int n = 0;
            while (exp_rsp_q.size() != 0 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("t5_rsp_drained", exp_rsp_q.size(), 0);
        @(negedge clk);
        check("t5_rsp_empty", o_Rsp_Valid, 0);
        @(posedge clk);
        #1;

        // Reset between the two strobes of a 2-byte frame.
        base = dv_cnt;
        push(8'h55, 1'b0);
        push(8'h66, 1'b1);
        wait_dv(base + 1, "t6_first_dv");
        rst_n = 1'b0;
        reset_model();
        #1 check_reset_values("t6_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = dv_cnt;
        push(8'h77, 1'b1);
        wait_dv(base + 1, "t6_after_dv");
        wait_idle("t6_drain");
        check("t6_count_after", o_TX_Count, 1);
        check("t6_dv_total", dv_cnt - base, 1);

        check("end_tx_queue", exp_tx_q.size(), 0);
        check("end_rsp_queue", exp_rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
